// File: rtl/cdc_hs_pkg.sv
// -----------------------------------------------------------------------------
// cdc_hs_pkg
// Shared types and limits for the receive end of the 4-phase req/ack
// clock-domain-crossing handshake (cdc_handshake_rx and cdc_sync_bit).
//   rx_state_t       : receiver FSM states IDLE / HOLD / ACK
//   SYNC_STAGES_MIN  : shallowest legal request synchronizer
//   SYNC_STAGES_MAX  : deepest legal request synchronizer
// -----------------------------------------------------------------------------
package cdc_hs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ACK  = 2'd2
    } rx_state_t;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // True when a synchronizer depth lies inside the supported range.
    function automatic bit sync_stages_ok(input int stages);
        return (stages >= SYNC_STAGES_MIN) && (stages <= SYNC_STAGES_MAX);
    endfunction

endpackage : cdc_hs_pkg

// File: rtl/cdc_sync_bit.sv
// -----------------------------------------------------------------------------
// cdc_sync_bit
// Single-bit multi-flop synchronizer for an asynchronous level.
// Parameters:
//   STAGES : number of flops in the chain
// Ports:
//   clk_i  in  destination clock
//   rst_ni in  asynchronous active-low reset (chain clears to 0)
//   d_i    in  asynchronous input level
//   q_o    out synchronized level, STAGES clk_i edges after d_i
// -----------------------------------------------------------------------------
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    // ASYNC_REG keeps the chain packed together and away from retiming.
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        sync_q[gi] <= 1'b0;
                    end else begin
                        sync_q[gi] <= d_i;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        sync_q[gi] <= 1'b0;
                    end else begin
                        sync_q[gi] <= sync_q[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign q_o = sync_q[STAGES-1];

endmodule : cdc_sync_bit

// File: rtl/cdc_handshake_rx.sv
// -----------------------------------------------------------------------------
// cdc_handshake_rx
// Receive end of a 4-phase req/ack CDC handshake, clocked only by clk_2.
// src_req is synchronized; src_data is sampled (never synchronized) once the
// synchronized request is seen in IDLE, then offered downstream on a
// valid/ready interface. dst_ack is returned after the word is accepted and
// cleared once the request has been withdrawn.
// Parameters:
//   DATA_WIDTH  : width of the crossed word
//   SYNC_STAGES : depth of the src_req synchronizer (2..4)
// Ports:
//   clk_2    in  destination clock
//   rst_n    in  asynchronous active-low reset
//   src_req  in  request level from the source domain
//   src_data in  source word, stable while the request is outstanding
//   dst_ack  out acknowledge level, straight from a flop
//   o_data   out captured word
//   o_valid  out o_data valid
//   i_ready  in  downstream accepts o_data
//   o_err    out sticky protocol-error flag
// Build option:
//   CDC_HANDSHAKE_RX_ERR_EN : when defined, a request withdrawn while the word
//   is still held (HOLD) sets o_err until reset; otherwise o_err is 0.
// -----------------------------------------------------------------------------
module cdc_handshake_rx
    import cdc_hs_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_2,
    input  logic                  rst_n,
    input  logic                  src_req,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  dst_ack,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_err
);

    generate
        if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync_stages
            $error("cdc_handshake_rx: SYNC_STAGES out of range");
        end
    endgenerate

    logic req_s;

    cdc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk_i  (clk_2),
        .rst_ni (rst_n),
        .d_i    (src_req),
        .q_o    (req_s)
    );

    rx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic                  valid_q, valid_d;
    logic                  ack_q,   ack_d;

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        ack_d   = ack_q;
        case (state_q)
            IDLE: begin
                // Level test is safe: IDLE is only re-entered after req_s=0.
                if (req_s) begin
                    data_d  = src_data;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // valid is always 1 here, so ready alone completes the beat.
                if (i_ready) begin
                    valid_d = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign dst_ack = ack_q;
    assign o_data  = data_q;
    assign o_valid = valid_q;

`ifdef CDC_HANDSHAKE_RX_ERR_EN
    logic err_q, err_d;

    // The source must keep req high until it sees ack; a drop in HOLD is a
    // violation. The transfer still finishes normally.
    assign err_d = err_q | ((state_q == HOLD) && !req_s);

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule : cdc_handshake_rx

// File: tb/tb_cdc_handshake_rx.sv
// -----------------------------------------------------------------------------
// tb_cdc_handshake_rx
// Directed phases plus a randomized 256-word stream from a clk_1 (100 MHz)
// source model into the clk_2 (~73 MHz) receiver. Expected words go into a
// queue when issued; a negedge monitor pops and compares on every accepted
// beat and also checks that a stalled word stays put.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cdc_handshake_rx;

    localparam int DW = 8;
    localparam int SS = 2;
    localparam int TMO = 500;

`ifdef CDC_HANDSHAKE_RX_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic          clk_1 = 1'b0;
    logic          clk_2 = 1'b0;
    logic          rst_n;
    logic          src_req;
    logic [DW-1:0] src_data;
    logic          dst_ack;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic          o_err;

    int checks = 0;
    int errors = 0;
    int pushed = 0;
    int rx_count = 0;
    logic err_exp = 1'b0;
    logic [DW-1:0] exp_q [$];

    // source-domain view of dst_ack
    logic ack_m = 1'b0;
    logic ack_s = 1'b0;
    bit   src_done = 1'b0;

    always #5     clk_1 = ~clk_1;
    always #6.849 clk_2 = ~clk_2;

    cdc_handshake_rx #(
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk_2    (clk_2),
        .rst_n    (rst_n),
        .src_req  (src_req),
        .src_data (src_data),
        .dst_ack  (dst_ack),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_err    (o_err)
    );

    always @(posedge clk_1) begin
        ack_m <= dst_ack;
        ack_s <= ack_m;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk_2);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        exp_q.push_back(w);
        pushed++;
    endtask

    // Monitor / scoreboard
    initial begin : monitor
        logic          hold_pend;
        logic [DW-1:0] held;
        logic [DW-1:0] e;
        hold_pend = 1'b0;
        held = '0;
        forever begin
            @(negedge clk_2);
            if (rst_n === 1'b1) begin
                if (hold_pend) begin
                    chk("stall_valid", {31'd0, o_valid}, 32'd1);
                    chk("stall_data", {24'd0, o_data}, {24'd0, held});
                end
                if (o_valid === 1'b1 && i_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", {24'd0, o_data}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rx_data", {24'd0, o_data}, {24'd0, e});
                        chk("rx_err", {31'd0, o_err}, {31'd0, err_exp});
                        rx_count++;
                        $display("RX #%0d word=%02h expected=%02h t=%0t", rx_count, o_data, e, $time);
                    end
                end
                hold_pend = (o_valid === 1'b1) && (i_ready === 1'b0);
                held = o_data;
            end else begin
                hold_pend = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        // Reset with a request already pending
        rst_n = 1'b0; src_req = 1'b1; src_data = 8'hA5; i_ready = 1'b0;
        edges(4);
        chk("rst_dst_ack", {31'd0, dst_ack}, 32'd0);
        chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_o_data", {24'd0, o_data}, 32'd0);
        chk("rst_o_err", {31'd0, o_err}, 32'd0);
        push_word(8'hA5);
        @(negedge clk_2) rst_n = 1'b1;
        edges(2);
        chk("rst_lat_early", {31'd0, o_valid}, 32'd0);
        edges(1);
        chk("rst_lat_valid", {31'd0, o_valid}, 32'd1);
        chk("rst_lat_data", {24'd0, o_data}, 32'hA5);
        i_ready = 1'b1;
        edges(1);
        chk("rst_acc_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_acc_ack", {31'd0, dst_ack}, 32'd1);
        src_req = 1'b0;
        edges(2);
        chk("rst_ack_hold", {31'd0, dst_ack}, 32'd1);
        edges(1);
        chk("rst_ack_fall", {31'd0, dst_ack}, 32'd0);
        $display("TXN reset-recapture done");

        // Single transfer, ready tied high
        edges(2);
        src_data = 8'h3C; push_word(8'h3C); src_req = 1'b1;
        edges(3);
        chk("single_valid", {31'd0, o_valid}, 32'd1);
        chk("single_data", {24'd0, o_data}, 32'h3C);
        edges(1);
        chk("single_pulse", {31'd0, o_valid}, 32'd0);
        chk("single_ack", {31'd0, dst_ack}, 32'd1);
        src_req = 1'b0;
        edges(2);
        chk("single_ack_hold", {31'd0, dst_ack}, 32'd1);
        edges(1);
        chk("single_ack_fall", {31'd0, dst_ack}, 32'd0);
        $display("TXN single transfer done");

        // Backpressure
        edges(2);
        i_ready = 1'b0;
        src_data = 8'h3C; push_word(8'h3C); src_req = 1'b1;
        edges(3);
        chk("bp_valid", {31'd0, o_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            edges(1);
            chk("bp_valid_hold", {31'd0, o_valid}, 32'd1);
            chk("bp_data_hold", {24'd0, o_data}, 32'h3C);
            chk("bp_no_ack", {31'd0, dst_ack}, 32'd0);
        end
        i_ready = 1'b1;
        edges(1);
        chk("bp_accept_valid", {31'd0, o_valid}, 32'd0);
        chk("bp_accept_ack", {31'd0, dst_ack}, 32'd1);
        edges(3);
        chk("bp_once_valid", {31'd0, o_valid}, 32'd0);
        chk("bp_ack_steady", {31'd0, dst_ack}, 32'd1);
        $display("TXN backpressure done");

        // Reset while in ACK with the request still high
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_ack", {31'd0, dst_ack}, 32'd0);
        chk("midrst_valid", {31'd0, o_valid}, 32'd0);
        push_word(8'h3C);
        @(negedge clk_2) rst_n = 1'b1;
        edges(3);
        chk("midrst_recap_valid", {31'd0, o_valid}, 32'd1);
        chk("midrst_recap_data", {24'd0, o_data}, 32'h3C);
        edges(1);
        chk("midrst_recap_ack", {31'd0, dst_ack}, 32'd1);
        src_req = 1'b0;
        edges(3);
        chk("midrst_ack_fall", {31'd0, dst_ack}, 32'd0);
        $display("TXN reset mid-handshake done");

        // Randomized stream 0x00..0xFF from the clk_1 source model
        edges(2);
        fork
            begin : source
                for (int w = 0; w < 256; w++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk_1);
                    @(posedge clk_1); #1;
                    src_data = w[DW-1:0];
                    push_word(w[DW-1:0]);
                    src_req = 1'b1;
                    n = 0;
                    while (ack_s !== 1'b1 && n < TMO) begin @(posedge clk_1); n++; end
                    if (n >= TMO) begin
                        chk("stream_ack_rise_timeout", 32'd0, 32'd1);
                        break;
                    end
                    #1 src_req = 1'b0;
                    n = 0;
                    while (ack_s !== 1'b0 && n < TMO) begin @(posedge clk_1); n++; end
                    if (n >= TMO) begin
                        chk("stream_ack_fall_timeout", 32'd1, 32'd0);
                        break;
                    end
                end
                src_done = 1'b1;
            end
            begin : sink
                while (!src_done) begin
                    @(posedge clk_2); #1;
                    i_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        i_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin edges(1); n++; end
        chk("stream_drained", exp_q.size(), 32'd0);
        chk("stream_count", rx_count, pushed);
        $display("TXN stream of 256 words done");

        // Request withdrawn while the word is held
        edges(4);
        i_ready = 1'b0;
        src_data = 8'h5A; push_word(8'h5A); src_req = 1'b1;
        edges(3);
        chk("perr_valid", {31'd0, o_valid}, 32'd1);
        chk("perr_err_before", {31'd0, o_err}, 32'd0);
        src_req = 1'b0;
        edges(3);
        chk("perr_err_set", {31'd0, o_err}, {31'd0, ERR_ON});
        chk("perr_still_valid", {31'd0, o_valid}, 32'd1);
        chk("perr_data", {24'd0, o_data}, 32'h5A);
        err_exp = ERR_ON;
        i_ready = 1'b1;
        edges(1);
        chk("perr_ack", {31'd0, dst_ack}, 32'd1);
        chk("perr_valid_drop", {31'd0, o_valid}, 32'd0);
        edges(1);
        chk("perr_ack_fall", {31'd0, dst_ack}, 32'd0);
        edges(5);
        chk("perr_err_sticky", {31'd0, o_err}, {31'd0, ERR_ON});
        chk("final_count", rx_count, pushed);
        $display("TXN protocol-error transfer done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cdc_handshake_rx

// File: doc/cdc_handshake_rx.md
Name: cdc_handshake_rx

Overview:
- Destination (receive) end of a 4-phase req/ack clock-domain-crossing handshake, clocked entirely in the clk_2 domain.
- A source in clk_1 holds src_data stable and raises src_req. This block synchronizes src_req, captures src_data, and presents it downstream on a valid/ready interface.
- Completes the handshake by returning dst_ack, a registered level read by the source domain through that domain's own synchronizer.

Parameters:
- DATA_WIDTH, 8: width of the crossed data word.
- SYNC_STAGES, 2: flip-flop depth of the src_req synchronizer; legal range 2..4.

Ports:
- clk_2  in  1  destination-domain clock; the only clock in the block.
- rst_n  in  1  asynchronous, active-low reset.
- src_req  in  1  asynchronous request level from the clk_1 domain.
- src_data  in  DATA_WIDTH  asynchronous data, guaranteed stable while src_req=1 and until dst_ack=1 is observed by the source.
- dst_ack  out  1  acknowledge level to the source domain; driven directly by a flop.
- o_data  out  DATA_WIDTH  captured word.
- o_valid  out  1  o_data valid.
- i_ready  in  1  downstream accepts o_data.
- o_err  out  1  sticky protocol-error flag; function defined under Optional Feature.

Behaviour:
- Reset (async assert, release synchronous to clk_2):
  - synchronizer chain = 0, state = IDLE.
  - dst_ack = 0, o_valid = 0, o_data = 0, o_err = 0.
- Synchronization:
  - req_s = src_req after SYNC_STAGES clk_2 flops.
  - src_data is never synchronized; it is sampled only in IDLE when req_s=1.
- FSM states: IDLE, HOLD, ACK.
  - IDLE:
    - if req_s=1: o_data <= src_data, o_valid <= 1, go to HOLD.
    - otherwise stay.
    - The condition is level-based, which is safe because IDLE is entered only after req_s=0 was seen.
  - HOLD:
    - o_valid=1, o_data held constant.
    - On o_valid & i_ready: o_valid <= 0, dst_ack <= 1, go to ACK.
    - If i_ready=0, stay indefinitely; backpressure stalls the source.
  - ACK:
    - if req_s=0: dst_ack <= 0, go to IDLE.
    - otherwise stay with dst_ack=1.
- Latency:
  - src_req rising edge → o_valid=1 after SYNC_STAGES+1 clk_2 edges.
  - i_ready=1 in the first HOLD cycle → dst_ack=1 on the next edge.
  - req_s fall → dst_ack=0 on the next edge.
- Throughput: at most one word per 4-phase round trip. A new word cannot be captured before IDLE is re-entered.
- Simultaneous events: in ACK, a req_s fall and a new src_req rise cannot both be seen, because the source does not re-raise until it sees dst_ack=0.
- Reset mid-transfer:
  - All state is cleared immediately and any pending word is dropped.
  - If src_req is still high after reset release, the word is recaptured and a fresh handshake starts.
- o_valid never falls without a handshake (AXI-style stability). o_data changes only on the IDLE→HOLD transition.

Optional Feature:
- Macro: CDC_HANDSHAKE_RX_ERR_EN.
- When defined:
  - In HOLD, req_s=0 is a source protocol violation.
  - o_err <= 1 and stays set until reset.
  - The FSM still completes the transfer normally: the held word is delivered, then ACK → IDLE on req_s=0.
- When undefined: o_err is tied to constant 0 and no detection logic is built.

Decomposition:
- Package cdc_hs_pkg:
  - rx_state_t enum {IDLE, HOLD, ACK}.
  - constants SYNC_STAGES_MIN=2 and SYNC_STAGES_MAX=4.
- Sub-module cdc_sync_bit (parameter STAGES):
  - single-bit flop chain with async active-low reset.
  - flops carry the ASYNC_REG attribute.
  - instantiated once for src_req.
- Elaboration assertion: SYNC_STAGES lies within the package limits.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 with src_req=1, src_data=8'hA5.
  - Response: dst_ack=0, o_valid=0, o_data=0. After release, o_valid=1 with o_data=8'hA5 after 3 clk_2 edges (SYNC_STAGES=2).
- Single transfer, i_ready tied 1:
  - Stimulus: src_data=8'h3C, raise src_req.
  - Response: o_valid pulses for 1 cycle with 8'h3C, then dst_ack=1. After src_req drops, dst_ack=0 SYNC_STAGES+1 edges later.
- Backpressure:
  - Stimulus: i_ready=0 for 10 cycles during HOLD.
  - Response: o_valid stays 1, o_data stays 8'h3C, dst_ack stays 0. On i_ready=1, the word is accepted exactly once and dst_ack rises.
- Back-to-back with asynchronous clocks:
  - Stimulus: clk_1=100 MHz and clk_2=73 MHz source model streams 0x00..0xFF.
  - Response: all 256 words arrive in order with no duplicates or drops; src_data changes only while dst_ack=1 or src_req=0.
- Reset mid-handshake:
  - Stimulus: assert rst_n=0 while in ACK.
  - Response: dst_ack drops asynchronously and the state returns to IDLE.
- Protocol error (CDC_HANDSHAKE_RX_ERR_EN defined):
  - Stimulus: drop src_req while in HOLD.
  - Response: o_err=1 and remains set; the word is still delivered. With the macro undefined, o_err stays 0 throughout.
